event_toggle_generator: RTL and testbench
=========================================

Name: event_toggle_generator

Overview:
- Transmit-side counterpart to the team's edge-based event detectors.
- Accepts single-cycle event requests on i_Event and encodes each one as one transition on o_Data.
- Enforces a minimum spacing of HOLD_CYCLES clocks between transitions, so a downstream detector on another path catches every event.
- Requests that arrive during the spacing window are queued in a saturating pending counter and issued in order.

Parameters:
HOLD_CYCLES, 4, minimum clocks between successive o_Data transitions; must be >= 1
PEND_W, 4, pending-counter width; maximum queued events = 2^PEND_W-1

Ports:
clk  input  1  single clock, rising-edge active
reset  input  1  asynchronous, active-high reset
i_Event  input  1  one event request per cycle high
i_Clear  input  1  synchronous flush of queued (not yet issued) events
o_Data  output  1  encoded event line; each transition = one event
o_Busy  output  1  high while holding or while pending != 0
o_Pending  output  PEND_W  count of queued, not-yet-issued events
o_Overflow  output  1  one-cycle pulse when an event is dropped

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: o_Data=0, o_Pending=0, o_Overflow=0, o_Busy=0, state=IDLE, timer=0.
  - Reset asserted mid-operation clears everything immediately, with no clock needed.
- States: IDLE and HOLD.
- "Issue in cycle c" means that at the rising edge ending cycle c, o_Data toggles and the timer loads HOLD_CYCLES-1.
- IDLE:
  - If i_Event=1 or pending!=0 -> issue; next state is HOLD.
  - Latency: i_Event high in cycle c gives an o_Data toggle visible in cycle c+1.
- HOLD:
  - While timer!=0, decrement.
  - When timer==0: if pending!=0 or i_Event=1 -> issue again and stay in HOLD; else -> IDLE.
  - Result: consecutive transitions are exactly HOLD_CYCLES apart under continuous demand.
  - HOLD_CYCLES=1 degenerates to one toggle per cycle.
- Pending source priority: an issue consumes a queued event first. A same-cycle i_Event is then counted into pending.
- Pending counter update per cycle:
  - +1 if i_Event is accepted and not consumed by an issue in that cycle.
  - -1 if an issue consumes a queued event and no new event is added.
  - Unchanged if both happen.
- Saturation:
  - If pending = 2^PEND_W-1, i_Event=1, and no issue occurs that cycle, the event is dropped.
  - o_Overflow pulses high in the following cycle; pending stays at max.
  - Never wraps to 0.
- i_Clear:
  - Pending goes to 0 at the next edge.
  - A same-cycle i_Event is discarded; no overflow pulse is raised for it.
  - The current HOLD timer and o_Data are unaffected; the in-flight transition is already issued.
  - i_Clear in IDLE with i_Event=1: no issue occurs (clear wins).
- o_Busy = (state==HOLD) | (pending!=0), derived from registers only, no combinational path from inputs.
- Every event is either issued, dropped (signalled by o_Overflow), or flushed by i_Clear.

Optional Feature:
- Macro: EVENT_TOGGLE_GEN_PULSE_MODE_EN.
- Defined:
  - o_Data uses pulse encoding instead of toggle encoding.
  - Each issued event drives o_Data high for HOLD_CYCLES cycles, then low for HOLD_CYCLES cycles.
  - States become IDLE/HIGH/LOW; successive rising edges are 2*HOLD_CYCLES apart.
  - Issue occurs only from IDLE or at LOW timer expiry.
  - Queueing, clear and overflow rules are unchanged.
- Undefined: toggle encoding as described in Behaviour.

Test Plan:
- Reset: assert reset asynchronously mid-HOLD with pending=3 -> all outputs 0 before the next clk edge; after release, no toggles until a new i_Event.
- Single event (HOLD_CYCLES=4): i_Event in cycle 10 only -> o_Data 0->1 visible cycle 11; o_Busy high cycles 11-14, low at 15; o_Pending stays 0.
- Burst: i_Event in cycles 10, 11, 12 -> toggles visible cycles 11, 15, 19; o_Pending 1, 2, then 1 at cycle 15, 0 at cycle 19; final o_Data=1.
- Overflow (PEND_W=4): i_Event held high from cycle 0 for 22 cycles -> o_Pending reaches 15 in cycle 20; first o_Overflow pulse in cycle 22; o_Pending never exceeds 15 or wraps.
- Clear: with pending=5 mid-HOLD, pulse i_Clear together with i_Event -> o_Pending=0 next cycle; current hold completes; no further toggles; o_Busy drops when the timer expires.
- Pulse mode (EVENT_TOGGLE_GEN_PULSE_MODE_EN, HOLD_CYCLES=3): events in cycles 5 and 6 -> o_Data high cycles 6-8, low 9-11, high 12-14, then low.

Source files
------------

// File: rtl/event_toggle_generator.sv
// Encodes single-cycle event requests as spaced transitions on o_Data, queueing bursts in a saturating counter.
// Optional pulse encoding (high/low for HOLD_CYCLES each) is built when EVENT_TOGGLE_GEN_PULSE_MODE_EN is defined.
module event_toggle_generator #(
    parameter int HOLD_CYCLES = 4,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_Event,
    input  logic              i_Clear,
    output logic              o_Data,
    output logic              o_Busy,
    output logic [PEND_W-1:0] o_Pending,
    output logic              o_Overflow
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0]     TIMER_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]     TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0]     TIMER_ONE  = TW'(1);
    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ZERO  = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

`ifdef EVENT_TOGGLE_GEN_PULSE_MODE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;
`endif

    state_t            state_r, state_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic [PEND_W-1:0] pend_r, pend_s;
    logic              data_r, data_s;
    logic              ovf_r, ovf_s;
    logic              busy_r, busy_s;
    logic              slot_s;
    logic              demand_s;
    logic              issue_s;
    logic              consume_s;

    // Encoder FSM: decides when an issue slot is open and what o_Data/timer do next.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        data_s   = data_r;
        slot_s   = 1'b0;
        // A clear flushes the queue and also suppresses any issue this cycle.
        demand_s = ~i_Clear & (i_Event | (pend_r != PEND_ZERO));
`ifdef EVENT_TOGGLE_GEN_PULSE_MODE_EN
        case (state_r)
            ST_IDLE: slot_s = 1'b1;
            ST_HIGH: begin
                if (timer_r == TIMER_ZERO) begin
                    state_s = ST_LOW;
                    data_s  = 1'b0;
                    timer_s = TIMER_LOAD;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_LOW: begin
                if (timer_r == TIMER_ZERO) begin
                    slot_s = 1'b1;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                data_s  = 1'b0;
                timer_s = TIMER_ZERO;
            end
        endcase
        issue_s = slot_s & demand_s;
        if (issue_s) begin
            state_s = ST_HIGH;
            data_s  = 1'b1;
            timer_s = TIMER_LOAD;
        end else if (slot_s) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
`else
        case (state_r)
            ST_IDLE: slot_s = 1'b1;
            ST_HOLD: begin
                if (timer_r == TIMER_ZERO) begin
                    slot_s = 1'b1;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = TIMER_ZERO;
            end
        endcase
        issue_s = slot_s & demand_s;
        if (issue_s) begin
            state_s = ST_HOLD;
            data_s  = ~data_r;
            timer_s = TIMER_LOAD;
        end else if (slot_s) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
`endif
    end

    // Pending queue: an issue drains a queued event first, a same-cycle request then refills it.
    always_comb begin
        pend_s    = pend_r;
        ovf_s     = 1'b0;
        consume_s = issue_s & (pend_r != PEND_ZERO);
        if (i_Clear) begin
            pend_s = PEND_ZERO;
        end else if (issue_s) begin
            if (consume_s && !i_Event) begin
                pend_s = pend_r - PEND_ONE;
            end else begin
                pend_s = pend_r;
            end
        end else if (i_Event) begin
            if (pend_r == PEND_MAX) begin
                ovf_s = 1'b1;
            end else begin
                pend_s = pend_r + PEND_ONE;
            end
        end else begin
            pend_s = pend_r;
        end
        busy_s = (state_s != ST_IDLE) | (pend_s != PEND_ZERO);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            timer_r <= TIMER_ZERO;
            pend_r  <= PEND_ZERO;
            data_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            pend_r  <= pend_s;
            data_r  <= data_s;
            ovf_r   <= ovf_s;
            busy_r  <= busy_s;
        end
    end

    assign o_Data     = data_r;
    assign o_Busy     = busy_r;
    assign o_Pending  = pend_r;
    assign o_Overflow = ovf_r;

endmodule

// File: tb/tb_event_toggle_generator.sv
// Self-checking bench for event_toggle_generator: directed vector tables, corner sequences and
// randomized traffic against a timing-rule reference model (also builds with EVENT_TOGGLE_GEN_PULSE_MODE_EN).
module tb_event_toggle_generator;

`ifdef EVENT_TOGGLE_GEN_PULSE_MODE_EN
    localparam int H    = 3;
    localparam int SPAN = 2 * H;
    localparam int NV   = 20;
`else
    localparam int H    = 4;
    localparam int SPAN = H;
    localparam int NV   = 18;
`endif
    localparam int PW   = 4;
    localparam int PMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_Event = 1'b0;
    logic          i_Clear = 1'b0;
    logic          o_Data, o_Busy, o_Overflow;
    logic [PW-1:0] o_Pending;

    always #5 clk = ~clk;

    event_toggle_generator #(.HOLD_CYCLES(H), .PEND_W(PW)) dut (
        .clk(clk), .reset(reset), .i_Event(i_Event), .i_Clear(i_Clear),
        .o_Data(o_Data), .o_Busy(o_Busy), .o_Pending(o_Pending), .o_Overflow(o_Overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: an issue may happen once SPAN cycles have passed since the previous one.
    int m_cyc = 0, m_last = 0, m_pend = 0, m_issues = 0;
    bit m_have = 1'b0, m_ovf = 1'b0;

    task automatic model_reset();
        m_pend = 0; m_issues = 0; m_have = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit ev, input bit clr);
        bit iss;
        m_ovf = 1'b0;
        if (clr) begin
            m_pend = 0;
        end else begin
            iss = (m_pend > 0 || ev) && (!m_have || m_cyc >= m_last + SPAN);
            if (iss) begin
                m_have = 1'b1; m_last = m_cyc; m_issues++;
                if (m_pend > 0 && !ev) m_pend--;
            end else if (ev) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else m_pend++;
            end
        end
        m_cyc++;
    endtask

    function automatic int exp_data();
`ifdef EVENT_TOGGLE_GEN_PULSE_MODE_EN
        return (m_have && m_cyc > m_last && m_cyc <= m_last + H) ? 1 : 0;
`else
        return m_issues % 2;
`endif
    endfunction

    function automatic int exp_busy();
        return ((m_have && m_cyc <= m_last + SPAN) || m_pend != 0) ? 1 : 0;
    endfunction

    task automatic step(input bit ev, input bit clr, input string tag);
        i_Event = ev;
        i_Clear = clr;
        model_step(ev, clr);
        @(posedge clk);
        #1;
        check({tag, ".data"}, o_Data, exp_data());
        check({tag, ".busy"}, o_Busy, exp_busy());
        check({tag, ".pend"}, o_Pending, m_pend);
        check({tag, ".ovf"}, o_Overflow, m_ovf);
    endtask

    task automatic apply_reset();
        i_Event = 1'b0;
        i_Clear = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst.data", o_Data, 0);
        check("rst.busy", o_Busy, 0);
        check("rst.pend", o_Pending, 0);
        check("rst.ovf", o_Overflow, 0);
    endtask

    typedef struct {
        bit rst; bit ev; bit clr; bit d; bit b; int p; bit o;
    } vec_t;
    vec_t tbl[NV];

    // Each entry: inputs for one cycle and the outputs expected in the following cycle.
    task automatic fill_tbl();
`ifdef EVENT_TOGGLE_GEN_PULSE_MODE_EN
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
`else
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_ovf, p20, d0, dens;
        reset = 1'b1;
        fill_tbl();
        apply_reset();

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst) begin
                apply_reset();
                repeat (3) step(1'b0, 1'b0, "idle");
            end
            step(tbl[i].ev, tbl[i].clr, "vec");
            check($sformatf("tbl%0d.data", i), o_Data, tbl[i].d);
            check($sformatf("tbl%0d.busy", i), o_Busy, tbl[i].b);
            check($sformatf("tbl%0d.pend", i), o_Pending, tbl[i].p);
            check($sformatf("tbl%0d.ovf", i), o_Overflow, tbl[i].o);
        end

        // Saturation: request held high for 22 cycles.
        apply_reset();
        first_ovf = -1;
        p20 = -1;
        for (int i = 0; i < 22; i++) begin
            step(1'b1, 1'b0, "ovf");
            if (o_Overflow === 1'b1 && first_ovf < 0) first_ovf = i + 1;
            if (i + 1 == 20) p20 = int'(o_Pending);
        end
`ifndef EVENT_TOGGLE_GEN_PULSE_MODE_EN
        check("ovf.pend_at_cycle20", p20, 15);
        check("ovf.first_pulse_cycle", first_ovf, 22);
`endif
        check("ovf.pend_saturated", o_Pending, 15);
        repeat (100) step(1'b0, 1'b0, "drain");

        // Clear together with a request while five events are queued mid-hold.
        apply_reset();
        repeat (7) step(1'b1, 1'b0, "fill");
        check("clr.pend_before", o_Pending, 5);
        d0 = int'(o_Data);
        step(1'b1, 1'b1, "clr");
        check("clr.pend_after", o_Pending, 0);
        check("clr.no_ovf", o_Overflow, 0);
`ifndef EVENT_TOGGLE_GEN_PULSE_MODE_EN
        check("clr.busy_hold", o_Busy, 1);
        check("clr.data_kept", o_Data, d0);
        step(1'b0, 1'b0, "clr_idle");
        check("clr.busy_drop", o_Busy, 0);
`endif
        repeat (8) begin
            step(1'b0, 1'b0, "clr_idle");
`ifndef EVENT_TOGGLE_GEN_PULSE_MODE_EN
            check("clr.no_toggle", o_Data, d0);
`endif
        end

        // Asynchronous reset mid-hold with three queued events.
        apply_reset();
        repeat (4) step(1'b1, 1'b0, "arst_fill");
        check("arst.pend_before", o_Pending, 3);
        i_Event = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("arst.data", o_Data, 0);
        check("arst.busy", o_Busy, 0);
        check("arst.pend", o_Pending, 0);
        check("arst.ovf", o_Overflow, 0);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (6) step(1'b0, 1'b0, "arst_quiet");

        // Randomized traffic with varying request density and occasional clears.
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            case ((i / 100) % 4)
                0: dens = 10;
                1: dens = 50;
                2: dens = 90;
                default: dens = 100;
            endcase
            step($urandom_range(0, 99) < dens, $urandom_range(0, 39) == 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
